// File: rtl/fpu_dispatch_if.sv
// Request/response bundle between an FPU front end and the dispatcher,
// including the operand/flag fan-out to the add, mult and div units.
interface fpu_dispatch_if;
  logic        data_valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] x_i;
  logic [31:0] y_i;
  logic [31:0] x_o;
  logic [31:0] y_o;
  logic        x_greater_o;
  logic [7:0]  exp_shift_o;
  logic [1:0]  inf_o;
  logic [1:0]  nan_o;
  logic [2:0]  start_o;
  logic [2:0]  done_i;
  logic [31:0] add_z_i;
  logic [31:0] mult_z_i;
  logic [31:0] div_z_i;
  logic [2:0]  invalid_i;
  logic [2:0]  overflow_i;
  logic        data_valid_o;
  logic [31:0] z_o;
  logic        except_invalid_operation_o;
  logic        except_overflow_o;

  modport slave (
    input  data_valid_i, op_i, x_i, y_i, done_i,
           add_z_i, mult_z_i, div_z_i, invalid_i, overflow_i,
    output ready_o, x_o, y_o, x_greater_o, exp_shift_o, inf_o, nan_o,
           start_o, data_valid_o, z_o,
           except_invalid_operation_o, except_overflow_o
  );

  modport master (
    output data_valid_i, op_i, x_i, y_i, done_i,
           add_z_i, mult_z_i, div_z_i, invalid_i, overflow_i,
    input  ready_o, x_o, y_o, x_greater_o, exp_shift_o, inf_o, nan_o,
           start_o, data_valid_o, z_o,
           except_invalid_operation_o, except_overflow_o
  );
endinterface

// File: rtl/fpu_dispatch.sv
// FPU request dispatcher: captures operands, selects one arithmetic unit,
// waits for that unit's done rising edge (or a timeout) and returns the
// result as a one-cycle pulse.
module fpu_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clk_i,
  input logic           rst_i,
  fpu_dispatch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  // Counter value seen during the last permitted WAIT cycle.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [2:0]  sel;
  logic [7:0]  cnt;
  logic [2:0]  done_prev;
  logic [31:0] x_cap;
  logic [31:0] y_cap;
  logic [31:0] z_res;
  logic        inv_res;
  logic        ovf_res;
  logic        vld_res;

  logic [2:0]  done_rise;
  logic        unit_done;
  logic [31:0] sel_z;
  logic        sel_inv;
  logic        sel_ovf;

  function automatic logic is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hff) && (v[22:0] == 23'd0);
  endfunction

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
  endfunction

  // Magnitude of the exponent difference; the signed 9-bit difference never overflows.
  function automatic logic [7:0] exp_distance(input logic [7:0] ex, input logic [7:0] ey);
    logic signed [8:0] diff;
    diff = $signed({1'b0, ex}) - $signed({1'b0, ey});
    return diff[8] ? 8'(-diff) : diff[7:0];
  endfunction

  // add serves both add and sub; sub arrives with y's sign already flipped.
  function automatic logic [2:0] unit_of(input logic [1:0] op);
    case (op)
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  assign done_rise = bus.done_i & ~done_prev;
  assign unit_done = |(done_rise & sel);

  // Route the selected unit's result and exception flags.
  always_comb begin
    sel_z   = bus.add_z_i;
    sel_inv = bus.invalid_i[0];
    sel_ovf = bus.overflow_i[0];
    if (sel[1]) begin
      sel_z   = bus.mult_z_i;
      sel_inv = bus.invalid_i[1];
      sel_ovf = bus.overflow_i[1];
    end else if (sel[2]) begin
      sel_z   = bus.div_z_i;
      sel_inv = bus.invalid_i[2];
      sel_ovf = bus.overflow_i[2];
    end
  end

  // Request FSM with operand capture, timeout counter and done history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sel       <= 3'b000;
      cnt       <= 8'd0;
      done_prev <= 3'b000;
      x_cap     <= 32'd0;
      y_cap     <= 32'd0;
      z_res     <= 32'd0;
      inv_res   <= 1'b0;
      ovf_res   <= 1'b0;
      vld_res   <= 1'b0;
    end else begin
      done_prev <= bus.done_i;
      vld_res   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.data_valid_i) begin
            x_cap <= bus.x_i;
            y_cap <= (bus.op_i == 2'b01) ? {~bus.y_i[31], bus.y_i[30:0]} : bus.y_i;
            sel   <= unit_of(bus.op_i);
            cnt   <= 8'd0;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (unit_done) begin
            z_res   <= sel_z;
            inv_res <= sel_inv;
            ovf_res <= sel_ovf;
            vld_res <= 1'b1;
            state   <= RESPOND;
          end else if (cnt == LAST_CNT) begin
            z_res   <= 32'h7fff_ffff;
            inv_res <= 1'b1;
            ovf_res <= 1'b0;
            vld_res <= 1'b1;
            state   <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o                    = (state == IDLE);
  assign bus.start_o                    = (state == WAIT) ? sel : 3'b000;
  assign bus.x_o                        = x_cap;
  assign bus.y_o                        = y_cap;
  assign bus.x_greater_o                = (x_cap[30:0] >= y_cap[30:0]);
  assign bus.exp_shift_o                = exp_distance(x_cap[30:23], y_cap[30:23]);
  assign bus.inf_o                      = {is_inf(y_cap), is_inf(x_cap)};
  assign bus.nan_o                      = {is_nan(y_cap), is_nan(x_cap)};
  assign bus.data_valid_o               = vld_res;
  assign bus.z_o                        = z_res;
  assign bus.except_invalid_operation_o = inv_res;
  assign bus.except_overflow_o          = ovf_res;

endmodule
